// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;

  // Responder control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response handshake bundle between the core memory
//               stage (master) and the data-memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : DEPTH x 32 word storage. Synchronous write, synchronous read
//               into a held output register, synchronous clear on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,   // forces the read register to zero
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage and read register; the read register holds its value between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[idx] <= wdata;
      end
      if (rd_clr) begin
        rdata_q <= '0;
      end else if (rd_en) begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Handshaked data-memory responder. Accepts one word request,
//               waits WAIT cycles, commits the access to dmem_array and holds
//               the response until consumed.
//               Optional macro DMEM_MISALIGN_ERR_EN: misaligned accesses are
//               suppressed and flagged on rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                mis_q, mis_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;

  // Commit-port controls toward the storage array
  logic                cm_en;
  logic                cm_we;
  logic                cm_mis;
  logic [IDX_W-1:0]    cm_idx;
  logic [DATA_W-1:0]   cm_wdata;
  logic                req_mis;
  logic [DATA_W-1:0]   array_rdata;
  logic                unused_addr_bits;

  // Address bits outside the word index only matter for the misalignment check
  assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:IDX_W+2], bus.req_addr[1:0]};

`ifdef DMEM_MISALIGN_ERR_EN
  assign req_mis = (bus.req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  // Next-state logic; with WAIT=0 the commit uses the request inputs directly
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    mis_d       = mis_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    cm_en       = 1'b0;
    cm_we       = we_q;
    cm_mis      = mis_q;
    cm_idx      = idx_q;
    cm_wdata    = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d        = bus.req_we;
          mis_d       = req_mis;
          idx_d       = bus.req_addr[IDX_W+1:2];
          wdata_d     = bus.req_wdata;
          req_ready_d = 1'b0;
          if (WAIT == 0) begin
            cm_en       = 1'b1;
            cm_we       = bus.req_we;
            cm_mis      = req_mis;
            cm_idx      = bus.req_addr[IDX_W+1:2];
            cm_wdata    = bus.req_wdata;
            rsp_err_d   = req_mis;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          cm_en       = 1'b1;
          rsp_err_d   = mis_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Control state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      mis_q       <= mis_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (cm_en & cm_we & ~cm_mis),
    .rd_en  (cm_en & ~cm_we & ~cm_mis),
    .rd_clr (cm_en & (cm_we | cm_mis)),
    .idx    (cm_idx),
    .wdata  (cm_wdata),
    .rdata  (array_rdata)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = array_rdata;
  assign bus.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
